serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor (a - b), LSB first.
// One full-subtractor cell is reused once per clock; a start/done handshake
// frames each operation, and diff/borrow are held between operations.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN adds a 'sub' input that
// selects subtract (1) or add (0); borrow then carries the adder's carry out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Counter must hold values 0..WIDTH; the last bit is processed at WIDTH-1.
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    bit_cnt;
  logic             bi;

  logic             x;
  logic             y;
  logic             d;
  logic             bo;
  logic             accept;
  logic             last;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             sub_q;
`endif

  // The single 1-bit cell: difference bit and borrow out (carry out in add mode).
  always_comb begin
    x  = a_sh[0];
    y  = b_sh[0];
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
`ifdef SERIAL_SUB_ADD_MODE_EN
    if (!sub_q) begin
      bo = (x & y) | ((x ^ y) & bi);
    end
`endif
  end

  // State register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs; a new start is taken in IDLE or DONE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then shift one bit per RUN cycle and
  // publish the assembled result only on the final bit so diff never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      bit_cnt <= '0;
      bi      <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      sub_q   <= 1'b1;
`endif
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      res_sh  <= '0;
      bit_cnt <= '0;
      bi      <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      sub_q   <= sub;
`endif
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= {d, res_sh[WIDTH-1:1]};
      bi      <= bo;
      bit_cnt <= bit_cnt + CW'(1);
      if (last) begin
        diff   <= {d, res_sh[WIDTH-1:1]};
        borrow <= bo;
      end
    end
  end

endmodule
